keypad_time_entry: RTL and testbench
====================================

Name: keypad_time_entry

Overview:
Parametrised keypad time-setting block for the nap timer. It accepts arbitrary multi-digit MM:SS entry from the one-hot digit keypad, with clear (star) and confirm (sharp) keys, and validates the entry. On a valid confirm it commits the value as packed BCD and pulses completeSetting to the countdown datapath. This block replaces the fixed three-preset selector.

Parameters:
MIN_DIGITS, 2, number of BCD minute digits. Total digits NUM_DIGITS = MIN_DIGITS+2 (localparam).
TIMEOUT_CYCLES, 50000000, idle cycles before an unfinished entry is aborted. Used only when KEYPAD_TIMEOUT_EN is defined.

Ports:
clock  input  1  system clock, rising edge
reset  input  1  synchronous, active-high reset
en  input  1  keypad entry enable
keypad  input  10  one-hot digit keys; bit d = digit d
sharp  input  1  confirm key
star  input  1  clear key
entry_bcd  output  4*NUM_DIGITS  live edit buffer; nibble 0 = seconds ones
digit_count  output  $clog2(NUM_DIGITS+1)  digits currently in the buffer
time_bcd  output  4*NUM_DIGITS  last committed time
completeSetting  output  1  one-cycle pulse on valid commit
entry_error  output  1  one-cycle pulse on rejected commit or timeout
editing  output  1  high while in ENTRY

Behaviour:
- One clock domain. Reset is synchronous and active-high. All outputs are registered.
- Reset value: state WAIT; entry_bcd, digit_count, time_bcd, completeSetting, entry_error, editing and the key-history registers are all 0.
- Press detection:
  - Key-history registers store the previous keypad, sharp and star values. They update every cycle, regardless of en or state.
  - A digit press is valid when keypad is exactly one-hot and the previous keypad was 0.
  - Multi-bit keypad values are ignored.
  - sharp and star presses are their rising edges.
  - A held key produces one event only.
- Event priority in the same cycle: star > sharp > digit. Only one event acts per cycle.
- When en = 0, all events are ignored. State and buffer hold.
- Timing: an event sampled at edge k updates state and outputs at edge k; they are visible in cycle k+1.
- States:
  - WAIT (buffer empty):
    - digit: buffer = digit, count = 1, go to ENTRY.
    - sharp and star: ignored.
  - ENTRY:
    - digit: if count < NUM_DIGITS, buffer shifts left one nibble, the new digit enters nibble 0, and count increments. If count = NUM_DIGITS, the digit is dropped with no change (saturate, no wrap).
    - star: buffer and count go to 0, go to WAIT.
    - sharp with a valid buffer: time_bcd <= buffer, buffer and count cleared, go to DONE.
    - sharp with an invalid buffer: buffer and count cleared, time_bcd unchanged, go to ERR.
    - A buffer is valid when its seconds-tens nibble is <= 5 and the buffer is not all zero.
  - DONE: completeSetting = 1 for exactly one cycle, then WAIT. Events are ignored.
  - ERR: entry_error = 1 for exactly one cycle, then WAIT. Events are ignored.
- editing = 1 exactly when the state is ENTRY.
- time_bcd holds its value until the next valid commit or reset.
- Reset mid-entry discards the buffer and clears time_bcd.

Optional Feature:
KEYPAD_TIMEOUT_EN
- Defined: an idle counter runs in ENTRY and resets on any accepted event. When it reaches TIMEOUT_CYCLES-1 with no event, the buffer is cleared and the state goes to ERR (entry_error pulse). The counter is 0 outside ENTRY.
- Undefined: there is no counter, and ENTRY persists indefinitely.

Test Plan:
- MIN_DIGITS=2, en=1. Press 1,3,0 then sharp -> entry_bcd 16'h0130 before sharp; time_bcd=16'h0130; completeSetting high exactly one cycle; digit_count=0.
- Press 0,7,5 then sharp -> entry_error one-cycle pulse; time_bcd keeps its previous value; state returns to WAIT.
- Hold keypad=10'b0000000100 for 10 cycles -> digit_count=1, entry_bcd=16'h0002. Press 1,2,3,4,5 -> entry_bcd=16'h1234, count saturates at 4.
- Press 4,2 then star -> entry_bcd=0, editing=0. Next: sharp alone in WAIT -> no pulse. keypad=10'b0000000110 -> ignored.
- Press 9 with en=0 -> no change. Press 5 with sharp on the same edge in ENTRY (buffer 16'h0001) -> commit of 16'h0001; digit 5 not entered. Reset asserted mid-entry -> all outputs 0 on the next cycle.
- With KEYPAD_TIMEOUT_EN and TIMEOUT_CYCLES=8: press 3, then idle -> entry_error pulse after 8 cycles, buffer 0. Without the macro -> buffer stays 16'h0003.

Source files
------------

// File: rtl/keypad_time_entry.sv
// Keypad MM:SS time entry with clear/confirm keys, validation and packed-BCD commit.
// Optional idle abort of an unfinished entry when KEYPAD_TIMEOUT_EN is defined.
module keypad_time_entry #(
    parameter int MIN_DIGITS     = 2,
    parameter int TIMEOUT_CYCLES = 50000000
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            en,
    input  logic [9:0]                      keypad,
    input  logic                            sharp,
    input  logic                            star,
    output logic [4*(MIN_DIGITS+2)-1:0]     entry_bcd,
    output logic [$clog2(MIN_DIGITS+3)-1:0] digit_count,
    output logic [4*(MIN_DIGITS+2)-1:0]     time_bcd,
    output logic                            completeSetting,
    output logic                            entry_error,
    output logic                            editing
);

    localparam int NUM_DIGITS = MIN_DIGITS + 2;
    localparam int BW         = 4 * NUM_DIGITS;
    localparam int CW         = $clog2(NUM_DIGITS + 1);

    localparam logic [BW-1:0] BUF_ZERO   = {BW{1'b0}};
    localparam logic [CW-1:0] COUNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] COUNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0] COUNT_FULL = CW'(NUM_DIGITS);

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2,
        ST_ERR   = 2'd3
    } state_t;

    function automatic logic is_onehot10(input logic [9:0] k);
        return (k != 10'd0) && ((k & (k - 10'd1)) == 10'd0);
    endfunction

    function automatic logic [3:0] onehot_to_digit(input logic [9:0] k);
        logic [3:0] d;
        d = 4'd0;
        for (int i = 0; i < 10; i++) begin
            d = d | (k[i] ? 4'(i) : 4'd0);
        end
        return d;
    endfunction

    // Seconds tens must be a legal 0-5 and a zero duration is meaningless.
    function automatic logic buffer_valid(input logic [BW-1:0] b);
        return (b[7:4] <= 4'd5) && (b != BUF_ZERO);
    endfunction

    state_t          state_r, state_next_s;
    logic [BW-1:0]   entry_r, entry_next_s;
    logic [CW-1:0]   count_r, count_next_s;
    logic [BW-1:0]   time_r, time_next_s;
    logic            complete_r, complete_next_s;
    logic            error_r, error_next_s;
    logic            editing_r, editing_next_s;
    logic [9:0]      keypad_prev_r;
    logic            sharp_prev_r;
    logic            star_prev_r;

    logic            star_act_s, sharp_act_s, digit_act_s, ev_any_s;
    logic [3:0]      digit_val_s;
    logic            timeout_s;

    // Only the highest-priority event of a cycle survives; en gates them all.
    assign star_act_s  = en & star & ~star_prev_r;
    assign sharp_act_s = en & sharp & ~sharp_prev_r & ~star_act_s;
    assign digit_act_s = en & is_onehot10(keypad) & (keypad_prev_r == 10'd0)
                         & ~star_act_s & ~sharp_act_s;
    assign ev_any_s    = star_act_s | sharp_act_s | digit_act_s;
    assign digit_val_s = onehot_to_digit(keypad);

`ifdef KEYPAD_TIMEOUT_EN
    localparam logic [31:0] TIMEOUT_LAST = 32'(TIMEOUT_CYCLES - 1);

    logic [31:0] idle_r, idle_next_s;

    assign timeout_s = (state_r == ST_ENTRY) && (idle_r == TIMEOUT_LAST);

    // Idle counter: counts only while ENTRY persists without an event.
    always_comb begin
        idle_next_s = 32'd0;
        if ((state_r == ST_ENTRY) && (state_next_s == ST_ENTRY) && !ev_any_s) begin
            idle_next_s = idle_r + 32'd1;
        end else begin
            idle_next_s = 32'd0;
        end
    end

    // Idle counter register.
    always_ff @(posedge clock) begin
        if (reset) begin
            idle_r <= 32'd0;
        end else begin
            idle_r <= idle_next_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // Next-state, edit buffer and registered-output next values.
    always_comb begin
        state_next_s = state_r;
        entry_next_s = entry_r;
        count_next_s = count_r;
        time_next_s  = time_r;
        case (state_r)
            ST_WAIT: begin
                if (digit_act_s) begin
                    entry_next_s = {{(BW-4){1'b0}}, digit_val_s};
                    count_next_s = COUNT_ONE;
                    state_next_s = ST_ENTRY;
                end else begin
                    state_next_s = ST_WAIT;
                end
            end
            ST_ENTRY: begin
                if (star_act_s) begin
                    entry_next_s = BUF_ZERO;
                    count_next_s = COUNT_ZERO;
                    state_next_s = ST_WAIT;
                end else if (sharp_act_s) begin
                    entry_next_s = BUF_ZERO;
                    count_next_s = COUNT_ZERO;
                    if (buffer_valid(entry_r)) begin
                        time_next_s  = entry_r;
                        state_next_s = ST_DONE;
                    end else begin
                        state_next_s = ST_ERR;
                    end
                end else if (digit_act_s) begin
                    // A full buffer saturates: extra digits are dropped.
                    if (count_r < COUNT_FULL) begin
                        entry_next_s = {entry_r[BW-5:0], digit_val_s};
                        count_next_s = count_r + COUNT_ONE;
                    end else begin
                        entry_next_s = entry_r;
                    end
                end else if (timeout_s) begin
                    entry_next_s = BUF_ZERO;
                    count_next_s = COUNT_ZERO;
                    state_next_s = ST_ERR;
                end else begin
                    state_next_s = ST_ENTRY;
                end
            end
            ST_DONE: state_next_s = ST_WAIT;
            ST_ERR:  state_next_s = ST_WAIT;
            default: state_next_s = ST_WAIT;
        endcase
        complete_next_s = (state_next_s == ST_DONE);
        error_next_s    = (state_next_s == ST_ERR);
        editing_next_s  = (state_next_s == ST_ENTRY);
    end

    // State, buffer, committed time, status pulses and key history.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_r       <= ST_WAIT;
            entry_r       <= BUF_ZERO;
            count_r       <= COUNT_ZERO;
            time_r        <= BUF_ZERO;
            complete_r    <= 1'b0;
            error_r       <= 1'b0;
            editing_r     <= 1'b0;
            keypad_prev_r <= 10'd0;
            sharp_prev_r  <= 1'b0;
            star_prev_r   <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            entry_r       <= entry_next_s;
            count_r       <= count_next_s;
            time_r        <= time_next_s;
            complete_r    <= complete_next_s;
            error_r       <= error_next_s;
            editing_r     <= editing_next_s;
            keypad_prev_r <= keypad;
            sharp_prev_r  <= sharp;
            star_prev_r   <= star;
        end
    end

    assign entry_bcd       = entry_r;
    assign digit_count     = count_r;
    assign time_bcd        = time_r;
    assign completeSetting = complete_r;
    assign entry_error     = error_r;
    assign editing         = editing_r;

endmodule

// File: tb/tb_keypad_time_entry.sv
// Self-checking bench for keypad_time_entry: directed vector table, idle/timeout
// sequence and randomized stimulus against a digit-queue reference model.
module tb_keypad_time_entry;

    localparam int MIN_DIGITS = 2;
    localparam int ND         = MIN_DIGITS + 2;
    localparam int TO         = 8;

    logic        clock = 1'b0;
    logic        reset, en, sharp, star;
    logic [9:0]  keypad;
    logic [15:0] entry_bcd, time_bcd;
    logic [2:0]  digit_count;
    logic        completeSetting, entry_error, editing;

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    keypad_time_entry #(.MIN_DIGITS(MIN_DIGITS), .TIMEOUT_CYCLES(TO)) dut (
        .clock(clock), .reset(reset), .en(en), .keypad(keypad),
        .sharp(sharp), .star(star), .entry_bcd(entry_bcd),
        .digit_count(digit_count), .time_bcd(time_bcd),
        .completeSetting(completeSetting), .entry_error(entry_error),
        .editing(editing)
    );

    typedef struct {
        logic        rst;
        logic        en;
        logic [9:0]  kp;
        logic        sh;
        logic        st;
        logic [15:0] entry;
        logic [2:0]  cnt;
        logic [15:0] tim;
        logic        cs;
        logic        err;
        logic        edit;
    } vec_t;

    vec_t vecs[$];

    // Reference model: the buffer is a queue of entered digits, oldest first.
    int          m_mode;          // 0 wait, 1 entry, 2 done, 3 err
    int          m_q[$];
    logic [15:0] m_time;
    logic [9:0]  m_pkp;
    logic        m_psh, m_pst;
    int          m_idle;

    function automatic logic [9:0] dk(input int d);
        return 10'd1 << d;
    endfunction

    function automatic void add(input logic r, input logic e, input logic [9:0] k,
                                input logic h, input logic s, input logic [15:0] ent,
                                input logic [2:0] c, input logic [15:0] t,
                                input logic cs, input logic er, input logic ed);
        vec_t v;
        v.rst = r; v.en = e; v.kp = k; v.sh = h; v.st = s;
        v.entry = ent; v.cnt = c; v.tim = t; v.cs = cs; v.err = er; v.edit = ed;
        vecs.push_back(v);
    endfunction

    function automatic logic [15:0] pack_q();
        int v;
        v = 0;
        foreach (m_q[i]) v = v * 16 + m_q[i];
        return 16'(v);
    endfunction

    function automatic bit q_valid();
        int  tens;
        bit  nz;
        tens = (m_q.size() >= 2) ? m_q[m_q.size()-2] : 0;
        nz = 0;
        foreach (m_q[i]) if (m_q[i] != 0) nz = 1;
        return (tens <= 5) && nz;
    endfunction

    task automatic model_step(input logic r, input logic e, input logic [9:0] k,
                              input logic h, input logic s);
        bit dp, a_st, a_sh, a_dg;
        int dv;
        if (r) begin
            m_mode = 0; m_q.delete(); m_time = 16'h0;
            m_pkp = 10'd0; m_psh = 1'b0; m_pst = 1'b0; m_idle = 0;
        end else begin
            dp = ($countones(k) == 1) && (m_pkp == 10'd0);
            dv = 0;
            for (int d = 0; d < 10; d++) if (k == dk(d)) dv = d;
            a_st = e && s && !m_pst;
            a_sh = e && h && !m_psh && !a_st;
            a_dg = e && dp && !a_st && !a_sh;
            case (m_mode)
                0: if (a_dg) begin m_q.delete(); m_q.push_back(dv); m_mode = 1; m_idle = 0; end
                1: begin
                    if (a_st) begin
                        m_q.delete(); m_mode = 0;
                    end else if (a_sh) begin
                        if (q_valid()) begin m_time = pack_q(); m_mode = 2; end
                        else m_mode = 3;
                        m_q.delete();
                    end else if (a_dg) begin
                        if (m_q.size() < ND) m_q.push_back(dv);
                        m_idle = 0;
`ifdef KEYPAD_TIMEOUT_EN
                    end else if (m_idle == TO - 1) begin
                        m_q.delete(); m_mode = 3;
`endif
                    end else begin
                        m_idle++;
                    end
                    if (m_mode != 1) m_idle = 0;
                end
                default: m_mode = 0;
            endcase
            m_pkp = k; m_psh = h; m_pst = s;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive_cycle(input logic r, input logic e, input logic [9:0] k,
                               input logic h, input logic s);
        reset = r; en = e; keypad = k; sharp = h; star = s;
        @(posedge clock);
        model_step(r, e, k, h, s);
        @(negedge clock);
    endtask

    task automatic check_model(input string tag);
        check({tag, "_entry"}, 32'(entry_bcd), 32'(pack_q()));
        check({tag, "_count"}, 32'(digit_count), 32'(m_q.size()));
        check({tag, "_time"}, 32'(time_bcd), 32'(m_time));
        check({tag, "_done"}, 32'(completeSetting), 32'(m_mode == 2));
        check({tag, "_err"}, 32'(entry_error), 32'(m_mode == 3));
        check({tag, "_edit"}, 32'(editing), 32'(m_mode == 1));
    endtask

    initial begin
        logic [9:0] kp;
        logic       r, e, h, s;
        int         sel;

        reset = 1'b1; en = 1'b1; keypad = 10'd0; sharp = 1'b0; star = 1'b0;

        // rst en kp sh st | entry cnt time cs err edit
        add(1,1,10'd0,0,0, 16'h0000,3'd0,16'h0000,0,0,0);
        add(0,1,dk(1),0,0, 16'h0001,3'd1,16'h0000,0,0,1);
        add(0,1,10'd0,0,0, 16'h0001,3'd1,16'h0000,0,0,1);
        add(0,1,dk(3),0,0, 16'h0013,3'd2,16'h0000,0,0,1);
        add(0,1,10'd0,0,0, 16'h0013,3'd2,16'h0000,0,0,1);
        add(0,1,dk(0),0,0, 16'h0130,3'd3,16'h0000,0,0,1);
        add(0,1,10'd0,0,0, 16'h0130,3'd3,16'h0000,0,0,1);
        add(0,1,10'd0,1,0, 16'h0000,3'd0,16'h0130,1,0,0);
        add(0,1,10'd0,1,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,dk(0),0,0, 16'h0000,3'd1,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0000,3'd1,16'h0130,0,0,1);
        add(0,1,dk(7),0,0, 16'h0007,3'd2,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0007,3'd2,16'h0130,0,0,1);
        add(0,1,dk(5),0,0, 16'h0075,3'd3,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0075,3'd3,16'h0130,0,0,1);
        add(0,1,10'd0,1,0, 16'h0000,3'd0,16'h0130,0,1,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        for (int i = 0; i < 10; i++) add(0,1,dk(2),0,0, 16'h0002,3'd1,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0002,3'd1,16'h0130,0,0,1);
        add(0,1,10'd0,0,1, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,dk(1),0,0, 16'h0001,3'd1,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0001,3'd1,16'h0130,0,0,1);
        add(0,1,dk(2),0,0, 16'h0012,3'd2,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0012,3'd2,16'h0130,0,0,1);
        add(0,1,dk(3),0,0, 16'h0123,3'd3,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0123,3'd3,16'h0130,0,0,1);
        add(0,1,dk(4),0,0, 16'h1234,3'd4,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h1234,3'd4,16'h0130,0,0,1);
        add(0,1,dk(5),0,0, 16'h1234,3'd4,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h1234,3'd4,16'h0130,0,0,1);
        add(0,1,10'd0,0,1, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'd0,1,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'h006,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,0,dk(9),0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0130,0,0,0);
        add(0,1,dk(1),0,0, 16'h0001,3'd1,16'h0130,0,0,1);
        add(0,1,10'd0,0,0, 16'h0001,3'd1,16'h0130,0,0,1);
        add(0,1,dk(5),1,0, 16'h0000,3'd0,16'h0001,1,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0001,0,0,0);
        add(0,1,dk(7),0,0, 16'h0007,3'd1,16'h0001,0,0,1);
        add(1,1,10'd0,0,0, 16'h0000,3'd0,16'h0000,0,0,0);
        add(0,1,10'd0,0,0, 16'h0000,3'd0,16'h0000,0,0,0);

        foreach (vecs[i]) begin
            drive_cycle(vecs[i].rst, vecs[i].en, vecs[i].kp, vecs[i].sh, vecs[i].st);
            check($sformatf("v%0d_entry", i), 32'(entry_bcd), 32'(vecs[i].entry));
            check($sformatf("v%0d_count", i), 32'(digit_count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_time", i), 32'(time_bcd), 32'(vecs[i].tim));
            check($sformatf("v%0d_done", i), 32'(completeSetting), 32'(vecs[i].cs));
            check($sformatf("v%0d_err", i), 32'(entry_error), 32'(vecs[i].err));
            check($sformatf("v%0d_edit", i), 32'(editing), 32'(vecs[i].edit));
        end

        // Idle after a single digit: aborts after TO cycles only with the timeout built in.
        drive_cycle(1, 1, 10'd0, 0, 0);
        drive_cycle(0, 1, dk(3), 0, 0);
        check("idle_press", 32'(entry_bcd), 32'h0003);
        for (int i = 1; i < TO; i++) begin
            drive_cycle(0, 1, 10'd0, 0, 0);
            check($sformatf("idle%0d_entry", i), 32'(entry_bcd), 32'h0003);
            check($sformatf("idle%0d_err", i), 32'(entry_error), 32'h0);
        end
        drive_cycle(0, 1, 10'd0, 0, 0);
`ifdef KEYPAD_TIMEOUT_EN
        check("timeout_err", 32'(entry_error), 32'h1);
        check("timeout_entry", 32'(entry_bcd), 32'h0000);
        check("timeout_edit", 32'(editing), 32'h0);
        drive_cycle(0, 1, 10'd0, 0, 0);
        check("timeout_pulse_end", 32'(entry_error), 32'h0);
`else
        check("noto_err", 32'(entry_error), 32'h0);
        for (int i = 0; i < 20; i++) drive_cycle(0, 1, 10'd0, 0, 0);
        check("noto_entry", 32'(entry_bcd), 32'h0003);
        check("noto_edit", 32'(editing), 32'h1);
`endif

        // Randomized stimulus against the reference model.
        drive_cycle(1, 1, 10'd0, 0, 0);
        check_model("rnd_rst");
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 299) == 0);
            e   = ($urandom_range(0, 9) != 0);
            sel = $urandom_range(0, 9);
            if (sel < 5)      kp = 10'd0;
            else if (sel < 9) kp = dk($urandom_range(0, 9));
            else              kp = 10'($urandom);
            h = ($urandom_range(0, 7) == 0);
            s = ($urandom_range(0, 15) == 0);
            drive_cycle(r, e, kp, h, s);
            check_model($sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
